// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and types for the register file
package regfile_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - decode/writeback side signals of the register file
interface register_file_if;
   import regfile_pkg::*;

   reg_addr_t r1;
   reg_addr_t r2;
   reg_addr_t write_r;
   reg_data_t data;
   logic      wr;
   reg_data_t out_r1;
   reg_data_t out_r2;

   // Datapath side: supplies addresses and write data, consumes operands.
   modport master (
      output r1, r2, write_r, data, wr,
      input  out_r1, out_r2
   );

   // Register file side.
   modport slave (
      input  r1, r2, write_r, data, wr,
      output out_r1, out_r2
   );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - combinational 32:1 operand read mux
module regfile_read_port
   import regfile_pkg::*;
(
   input  reg_data_t regs_i [DEPTH],
   input  reg_addr_t addr_i,
   output reg_data_t data_o
);

   // Array depth equals 2**ADDR_W, so every address selects a real entry;
   // an unknown address propagates as an unknown operand.
   assign data_o = regs_i[addr_i];

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x16 register file, two async read ports, one sync write port
module register_file
   import regfile_pkg::*;
(
   input  logic           clock,
   input  logic           reset_n,
   register_file_if.slave bus
);

   reg_data_t mem_q [DEPTH];
   reg_data_t mem_d [DEPTH];

   // Next-state of the storage: at most the addressed entry takes the write data.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (bus.wr) begin
         mem_d[bus.write_r] = bus.data;
      end
   end

   // Storage: reset clears every entry at once, including entry 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Reads see registered contents only, so a same-cycle write shows up after the edge.
   regfile_read_port u_read_r1 (
      .regs_i (mem_q),
      .addr_i (bus.r1),
      .data_o (bus.out_r1)
   );

   regfile_read_port u_read_r2 (
      .regs_i (mem_q),
      .addr_i (bus.r2),
      .data_o (bus.out_r2)
   );

   // A write with an unknown address would corrupt an unpredictable entry.
   wr_addr_known: assert property (
      @(posedge clock) disable iff (!reset_n) bus.wr |-> !$isunknown(bus.write_r)
   );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;
   import regfile_pkg::*;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   register_file_if bus ();

   register_file dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference contents of the 32 registers.
   reg_data_t model [DEPTH];

   string     name_q [$];
   reg_data_t e1_q   [$];
   reg_data_t e2_q   [$];
   event      sample_ev;

   // Monitor: whenever the bench announces a sample point, compare both read ports.
   initial begin
      forever begin
         @(sample_ev);
         while (e1_q.size() > 0) begin
            string     nm;
            reg_data_t e1;
            reg_data_t e2;
            nm = name_q.pop_front();
            e1 = e1_q.pop_front();
            e2 = e2_q.pop_front();
            checks++;
            if (bus.out_r1 !== e1 || bus.out_r2 !== e2) begin
               errors++;
               $display("FAIL %s: got out_r1=%h out_r2=%h, expected out_r1=%h out_r2=%h (r1=%0d r2=%0d) at %0t",
                        nm, bus.out_r1, bus.out_r2, e1, e2, bus.r1, bus.r2, $time);
            end
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         model[i] = '0;
      end
   endtask

   // Drive read addresses, then hand the expected operands to the monitor.
   task automatic check(input string nm, input reg_addr_t a1, input reg_addr_t a2);
      bus.r1 = a1;
      bus.r2 = a2;
      #1;
      name_q.push_back(nm);
      e1_q.push_back(model[a1]);
      e2_q.push_back(model[a2]);
      -> sample_ev;
      #1;
   endtask

   // Present a write request for one clock edge; the model only accepts it out of reset.
   task automatic write_edge(input logic we, input reg_addr_t a, input reg_data_t d);
      @(negedge clock);
      bus.wr      = we;
      bus.write_r = a;
      bus.data    = d;
      @(posedge clock);
      if (we && reset_n) begin
         model[a] = d;
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      bus.r1      = '0;
      bus.r2      = '0;
      bus.write_r = '0;
      bus.data    = '0;
      bus.wr      = 1'b0;
      model_clear();

      // Reset: cleared during reset and after release.
      #2;
      reset_n = 1'b0;
      check("reset_during", 5'd3, 5'd17);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check("reset_sweep", reg_addr_t'(i), reg_addr_t'(DEPTH - 1 - i));
      end

      // Sequential write and readback.
      write_edge(1'b1, 5'd0, 16'h3524);
      write_edge(1'b1, 5'd1, 16'h5E81);
      write_edge(1'b1, 5'd2, 16'hD609);
      write_edge(1'b1, 5'd3, 16'h5663);
      bus.wr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("seq_readback", reg_addr_t'(i), reg_addr_t'(i));
      end

      // Write enable gating.
      repeat (4) write_edge(1'b0, 5'd5, 16'hFFFF);
      check("wr_gate", 5'd5, 5'd5);

      // Dual-port independence and combinational swap.
      write_edge(1'b1, 5'd7, 16'hAAAA);
      write_edge(1'b1, 5'd31, 16'h5555);
      bus.wr = 1'b0;
      @(negedge clock);
      check("dual_port", 5'd7, 5'd31);
      check("dual_swap", 5'd31, 5'd7);

      // Read during write: old value before the edge, new value after it.
      write_edge(1'b1, 5'd4, 16'h1111);
      @(negedge clock);
      bus.wr      = 1'b1;
      bus.write_r = 5'd4;
      bus.data    = 16'h2222;
      check("rdw_before", 5'd4, 5'd4);
      @(posedge clock);
      model[4] = 16'h2222;
      check("rdw_after", 5'd4, 5'd4);
      bus.wr = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         logic      we;
         reg_addr_t wa;
         reg_data_t wd;
         we = 1'($urandom_range(0, 1));
         wa = reg_addr_t'($urandom_range(0, DEPTH - 1));
         wd = reg_data_t'($urandom);
         write_edge(we, wa, wd);
         check("random", reg_addr_t'($urandom_range(0, DEPTH - 1)),
               reg_addr_t'($urandom_range(0, DEPTH - 1)));
      end
      bus.wr = 1'b0;

      // Asynchronous reset mid-operation.
      for (int i = 0; i < DEPTH; i++) begin
         write_edge(1'b1, reg_addr_t'(i), reg_data_t'(i));
      end
      bus.wr = 1'b0;
      @(negedge clock);
      check("filled", 5'd9, 5'd31);
      @(negedge clock);
      #1;
      reset_n = 1'b0;
      model_clear();
      check("async_clear", 5'd9, 5'd31);
      write_edge(1'b1, 5'd9, 16'hBEEF);
      bus.wr = 1'b0;
      check("write_in_reset", 5'd9, 5'd9);
      @(negedge clock);
      reset_n = 1'b1;
      check("lost_write", 5'd9, 5'd1);
      check("post_reset", 5'd31, 5'd0);

      #5;
      checks++;
      if (e1_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", e1_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
